nibble_tx_module: RTL and testbench
===================================

NIBBLE_TX_MODULE -- requirements
Module: nibble_tx_module

Interface
REQ-001 The block SHALL be configured by parameter DEPTH, default 4, meaning the number of FIFO entries (power of 2, minimum 2).
REQ-002 The block SHALL be configured by parameter GAP, default 2, meaning the number of idle cycles inserted after each transmitted word (0 to 15).
REQ-003 The block SHALL have port CLK  input  1  single system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port In_Valid  input  1  upstream word present.
REQ-006 The block SHALL have port In_Data  input  4  upstream nibble.
REQ-007 The block SHALL have port In_Ready  output  1  FIFO can accept a word this cycle.
REQ-008 The block SHALL have port Dout  output  4  registered transmit nibble, driven toward the downstream capture register.
REQ-009 The block SHALL have port Dout_Strobe  output  1  registered; high for exactly one cycle when Dout carries a new word.
REQ-010 The block SHALL have port Busy  output  1  high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-011 A push SHALL occur on a cycle with In_Valid=1 and In_Ready=1; In_Data is written at the FIFO write pointer.
REQ-012 In_Ready SHALL be the inverse of full (count==DEPTH); it SHALL NOT depend combinationally on In_Valid.
REQ-013 The FSM SHALL have exactly three states: IDLE, SEND and HOLD.
REQ-014 In IDLE with count>0, the FSM SHALL pop one word and go to SEND; with count==0 it SHALL stay in IDLE.
REQ-015 SEND SHALL last one cycle, with Dout=popped word and Dout_Strobe=1.
REQ-016 From SEND, the FSM SHALL go to HOLD (gap counter loaded with GAP) if GAP>0.
REQ-017 From SEND with GAP==0, the FSM SHALL pop again and stay in SEND if count>0, else go to IDLE.
REQ-018 In HOLD, the gap counter SHALL decrement each cycle; on reaching 0 the FSM SHALL take the IDLE decision (REQ-014) in that same cycle.
REQ-019 Strobe spacing SHALL be exactly GAP+1 cycles while the FIFO stays non-empty.
REQ-020 Latency: a word pushed into an empty FIFO in an IDLE state at cycle n SHALL appear on Dout, with Dout_Strobe=1, at cycle n+2.
REQ-021 Dout SHALL hold its last value between strobes; Dout_Strobe SHALL be 0 outside SEND.
REQ-022 A simultaneous push and pop SHALL leave count unchanged, and the two words SHALL keep FIFO order.
REQ-023 When the FIFO is full, a pop in a cycle SHALL raise In_Ready in the next cycle, never in the same cycle.
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits wide and never exceed DEPTH.
REQ-025 Words SHALL leave in push order with no loss or duplication.

Reset
REQ-026 While RST=1 at a clock edge: state=IDLE, pointers=0, count=0, gap counter=0, Dout=4'd0, Dout_Strobe=0, In_Ready=1 after that edge, Busy=0.
REQ-027 Reset asserted mid-operation SHALL discard all FIFO contents and any HOLD in progress; no strobe SHALL occur in the cycle after the reset edge.

Configuration
REQ-028 When macro NIBBLE_TX_PARITY_EN is defined, the block SHALL add output Dout_Par (1 bit), registered with Dout, equal to the even parity (XOR) of Dout and reset to 0.
REQ-029 When NIBBLE_TX_PARITY_EN is not defined, Dout_Par and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then push 4'hA at cycle 1 -> Dout=4'hA and Dout_Strobe=1 at cycle 3 only; Busy falls after the HOLD ends.
REQ-031 With GAP=2, push A,B,C back-to-back -> strobes at cycles 3, 6 and 9 with Dout A, B, C; In_Ready stays 1 throughout.
REQ-032 With DEPTH=4, hold In_Valid=1 for 10 cycles with values 0..9 -> In_Ready drops when full, exactly the accepted words appear in order, and no word is dropped or duplicated.
REQ-033 With GAP=0 and the FIFO full -> 4 consecutive strobe cycles, with In_Ready re-rising one cycle after the first pop.
REQ-034 Assert RST during HOLD with 3 words queued -> no further strobes, Dout=0, count=0; a new push afterwards transmits normally.
REQ-035 With NIBBLE_TX_PARITY_EN defined, send 4'h7 then 4'h3 -> Dout_Par=1 then 0, aligned with the strobes.

Source files
------------

// File: rtl/nibble_tx_module.sv
// Nibble transmitter: DEPTH-entry FIFO drained by an IDLE/SEND/HOLD FSM with GAP idle cycles per word.
// Optional macro NIBBLE_TX_PARITY_EN adds the registered even-parity output Dout_Par.
module nibble_tx_module #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       In_Valid,
  input  logic [3:0] In_Data,
  output logic       In_Ready,
  output logic [3:0] Dout,
  output logic       Dout_Strobe,
  output logic       Busy
`ifdef NIBBLE_TX_PARITY_EN
  ,
  output logic       Dout_Par
`endif
);

  localparam int            AW    = $clog2(DEPTH);
  localparam int            CW    = AW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [3:0]    GAP_L = 4'(GAP);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    gap_q, gap_d;
  logic [3:0]    dout_q, dout_d;
  logic          strobe_q, strobe_d;
  logic          push, pop;

  assign In_Ready    = (count_q != FULL);
  assign push        = In_Valid & In_Ready;
  assign Busy        = (count_q != '0) | (state_q != IDLE);
  assign Dout        = dout_q;
  assign Dout_Strobe = strobe_q;

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    dout_d   = dout_q;
    strobe_d = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      SEND: begin
        if (GAP_L != 4'd0) begin
          state_d = HOLD;
          gap_d   = GAP_L;
        end else if (count_q != '0) begin
          pop = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        gap_d = gap_q - 4'd1;
        // The last hold cycle doubles as the IDLE decision, keeping spacing at GAP+1.
        if (gap_q == 4'd1) begin
          if (count_q != '0) pop = 1'b1;
          else               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d  = SEND;
      dout_d   = mem_q[rd_ptr_q];
      strobe_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      gap_q    <= '0;
      dout_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
    end
  end

  // Storage is not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= In_Data;
  end

`ifdef NIBBLE_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge CLK) begin
    if (RST) par_q <= 1'b0;
    else     par_q <= ^dout_d;
  end

  assign Dout_Par = par_q;
`endif

endmodule

// File: tb/tb_nibble_tx_module.sv
// Directed bench for nibble_tx_module: default instance (DEPTH=4, GAP=2) plus a GAP=0 instance.
module tb_nibble_tx_module;

  logic       CLK = 1'b0;
  logic       RST;
  logic       In_Valid;
  logic [3:0] In_Data;
  logic       In_Ready;
  logic [3:0] Dout;
  logic       Dout_Strobe;
  logic       Busy;
  logic       g_Valid;
  logic [3:0] g_Data;
  logic       g_Ready;
  logic [3:0] g_Dout;
  logic       g_Strobe;
  logic       g_Busy;
`ifdef NIBBLE_TX_PARITY_EN
  logic       Dout_Par;
  logic       g_Par;
`endif

  int errors = 0;
  int checks = 0;

  nibble_tx_module #(.DEPTH(4), .GAP(2)) dut (
    .CLK(CLK), .RST(RST), .In_Valid(In_Valid), .In_Data(In_Data),
    .In_Ready(In_Ready), .Dout(Dout), .Dout_Strobe(Dout_Strobe), .Busy(Busy)
`ifdef NIBBLE_TX_PARITY_EN
    , .Dout_Par(Dout_Par)
`endif
  );

  nibble_tx_module #(.DEPTH(4), .GAP(0)) u_g0 (
    .CLK(CLK), .RST(RST), .In_Valid(g_Valid), .In_Data(g_Data),
    .In_Ready(g_Ready), .Dout(g_Dout), .Dout_Strobe(g_Strobe), .Busy(g_Busy)
`ifdef NIBBLE_TX_PARITY_EN
    , .Dout_Par(g_Par)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; In_Valid = 1'b0; In_Data = 4'h0; g_Valid = 1'b0; g_Data = 4'h0;
    tick(); tick();
    RST = 1'b0;
    checks++; if (Dout !== 4'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", Dout); end
    checks++; if (Dout_Strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", Dout_Strobe); end
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", In_Ready); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (g_Dout !== 4'h0 || g_Strobe !== 1'b0) begin errors++; $display("FAIL reset_g0: got %h/%b want 0/0", g_Dout, g_Strobe); end
  endtask

  task automatic test_latency();
    tick(); In_Valid = 1'b1; In_Data = 4'hA;
    tick(); In_Valid = 1'b0;
    checks++; if (Dout_Strobe !== 1'b0) begin errors++; $display("FAIL lat_c2_strobe: got %b want 0", Dout_Strobe); end
    tick();
    checks++; if (Dout_Strobe !== 1'b1 || Dout !== 4'hA) begin errors++; $display("FAIL lat_c3: got %b/%h want 1/a", Dout_Strobe, Dout); end
    tick();
    checks++; if (Dout_Strobe !== 1'b0 || Dout !== 4'hA || Busy !== 1'b1) begin errors++; $display("FAIL lat_c4: got %b/%h/%b want 0/a/1", Dout_Strobe, Dout, Busy); end
    tick();
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL lat_c5_busy: got %b want 1", Busy); end
    tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL lat_c6_busy: got %b want 0", Busy); end
  endtask

  task automatic test_back_to_back();
    logic       exp_s;
    logic [3:0] exp_d;
    for (int i = 1; i <= 14; i++) begin
      tick();
      In_Valid = (i <= 3);
      In_Data  = 4'hA + 4'(i - 1);
      exp_s = (i == 3) || (i == 6) || (i == 9);
      exp_d = (i >= 9) ? 4'hC : (i >= 6) ? 4'hB : 4'hA;
      checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c%0d: got %b want 1", i, In_Ready); end
      checks++; if (Dout_Strobe !== exp_s || Dout !== exp_d) begin
        errors++; $display("FAIL b2b_out c%0d: got %b/%h want %b/%h", i, Dout_Strobe, Dout, exp_s, exp_d);
      end
    end
    In_Valid = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", Busy); end
  endtask

  task automatic test_fill();
    logic       rdy_tab [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_tab [7]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8};
    int         cyc_tab [7]  = '{3, 6, 9, 12, 15, 18, 21};
    int         nstrb = 0;
    for (int i = 1; i <= 26; i++) begin
      tick();
      if (i <= 10) begin
        checks++; if (In_Ready !== rdy_tab[i-1]) begin errors++; $display("FAIL fill_ready c%0d: got %b want %b", i, In_Ready, rdy_tab[i-1]); end
        In_Valid = 1'b1;
        In_Data  = 4'(i - 1);
      end else begin
        In_Valid = 1'b0;
      end
      if (Dout_Strobe === 1'b1) begin
        if (nstrb < 7) begin
          checks++; if (Dout !== exp_tab[nstrb] || i != cyc_tab[nstrb]) begin
            errors++; $display("FAIL fill_word%0d: got %h at c%0d want %h at c%0d", nstrb, Dout, i, exp_tab[nstrb], cyc_tab[nstrb]);
          end
        end
        nstrb++;
      end
    end
    checks++; if (nstrb != 7) begin errors++; $display("FAIL fill_count: got %0d strobes want 7", nstrb); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL fill_busy_end: got %b want 0", Busy); end
  endtask

  task automatic test_gap0();
    logic       exp_s;
    logic [3:0] exp_d;
    for (int i = 1; i <= 8; i++) begin
      tick();
      g_Valid = (i <= 4);
      g_Data  = 4'(i + 4);
      exp_s = (i >= 3) && (i <= 6);
      exp_d = (i < 3) ? 4'h0 : (i > 6) ? 4'h8 : 4'(i + 2);
      checks++; if (g_Ready !== 1'b1) begin errors++; $display("FAIL g0_ready c%0d: got %b want 1", i, g_Ready); end
      checks++; if (g_Strobe !== exp_s || g_Dout !== exp_d) begin
        errors++; $display("FAIL g0_out c%0d: got %b/%h want %b/%h", i, g_Strobe, g_Dout, exp_s, exp_d);
      end
    end
    g_Valid = 1'b0;
    checks++; if (g_Busy !== 1'b0) begin errors++; $display("FAIL g0_busy_end: got %b want 0", g_Busy); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 4; i++) begin
      tick();
      In_Valid = 1'b1;
      In_Data  = 4'(i);
      if (i == 3) begin
        checks++; if (Dout_Strobe !== 1'b1 || Dout !== 4'h1) begin errors++; $display("FAIL rst_mid_first: got %b/%h want 1/1", Dout_Strobe, Dout); end
      end
    end
    tick();
    In_Valid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (Dout_Strobe !== 1'b0 || Dout !== 4'h0) begin errors++; $display("FAIL rst_mid_out: got %b/%h want 0/0", Dout_Strobe, Dout); end
    checks++; if (Busy !== 1'b0 || In_Ready !== 1'b1) begin errors++; $display("FAIL rst_mid_flags: got busy %b ready %b want 0/1", Busy, In_Ready); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (Dout_Strobe !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet %0d: got %b want 0", i, Dout_Strobe); end
    end
    In_Valid = 1'b1; In_Data = 4'h5;
    tick(); In_Valid = 1'b0;
    tick();
    checks++; if (Dout_Strobe !== 1'b1 || Dout !== 4'h5) begin errors++; $display("FAIL rst_mid_resume: got %b/%h want 1/5", Dout_Strobe, Dout); end
    repeat (4) tick();
  endtask

`ifdef NIBBLE_TX_PARITY_EN
  task automatic test_parity();
    for (int i = 1; i <= 7; i++) begin
      tick();
      In_Valid = (i <= 2);
      In_Data  = (i == 1) ? 4'h7 : 4'h3;
      if (i == 3) begin
        checks++; if (Dout_Strobe !== 1'b1 || Dout !== 4'h7 || Dout_Par !== 1'b1) begin
          errors++; $display("FAIL par_7: got %b/%h/%b want 1/7/1", Dout_Strobe, Dout, Dout_Par);
        end
      end
      if (i == 6) begin
        checks++; if (Dout_Strobe !== 1'b1 || Dout !== 4'h3 || Dout_Par !== 1'b0) begin
          errors++; $display("FAIL par_3: got %b/%h/%b want 1/3/0", Dout_Strobe, Dout, Dout_Par);
        end
      end
    end
    In_Valid = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_fill();
    test_gap0();
    test_reset_mid();
`ifdef NIBBLE_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
